// File: rtl/sad_controller.sv
// SAD sequencer: walks AB_addr over the A/B block memories,
// accumulates |A-B| and publishes the total on sad with a done pulse.
module sad_controller #(
  parameter int N      = 256,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] A_data,
  input  logic [DATA_W-1:0] B_data,
  output logic [ADDR_W-1:0] AB_addr,
  output logic              AB_rd,
  output logic [SUM_W-1:0]  sad,
  output logic              done,
  output logic              busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] ACC   = 3'd4;
  localparam logic [2:0] OUT   = 3'd5;

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(N);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [ADDR_W-1:0] i;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] diff;
  logic              in_range;

  assign in_range = (i < LIMIT);

  always_comb begin
    diff = (A_data >= B_data) ? (A_data - B_data)
                              : (B_data - A_data);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? INIT : IDLE;
      INIT:    state_nx = CHECK;
      CHECK:   state_nx = in_range ? READ : OUT;
      READ:    state_nx = ACC;
      ACC:     state_nx = CHECK;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      sum   <= '0;
      sad   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        INIT: begin
          sum <= '0;
          i   <= '0;
        end
        CHECK: begin
          if (!in_range) sad <= sum;
        end
        ACC: begin
          sum <= sum + SUM_W'(diff);
          i   <= i + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register
  assign AB_addr = i;
  assign AB_rd   = (state == READ);
  assign done    = (state == OUT);
  assign busy    = (state != IDLE);

endmodule
